// File: rtl/emulador_hcsr04.sv
// HC-SR04 ultrasonic sensor emulator: measures the trigger pulse, waits the burst time,
// then answers with an echo pulse whose width encodes a 3-digit BCD distance.
module emulador_hcsr04 #(
    parameter int LARGURA_MIN = 500,
    parameter int ATRASO      = 25000,
    parameter int R           = 2941,
    parameter int ECO_MAX     = 1900000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [11:0] distancia,
    output logic        echo,
    output logic        pronto,
    output logic        erro,
    output logic [2:0]  db_estado
);

    localparam int W_LARG_MIN = $clog2(LARGURA_MIN + 1);
    localparam int W_LARG     = (W_LARG_MIN > 10) ? W_LARG_MIN : 10;
    localparam int W_ESP_MIN  = $clog2(ATRASO + 1);
    localparam int W_ESP      = (W_ESP_MIN > 1) ? W_ESP_MIN : 1;
    localparam int W_ECO_A    = $clog2(ECO_MAX + 1);
    localparam int W_ECO_B    = $clog2(400 * R + 1);
    localparam int W_ECO_AB   = (W_ECO_A > W_ECO_B) ? W_ECO_A : W_ECO_B;
    localparam int W_ECO      = (W_ECO_AB > 21) ? W_ECO_AB : 21;

    typedef enum logic [2:0] {
        INICIAL      = 3'd0,
        MEDE_TRIGGER = 3'd1,
        ESPERA       = 3'd2,
        ECO          = 3'd3,
        FIM          = 3'd4
    } estado_t;

    estado_t            estado, estado_prox;
    logic               erro_prox;
    logic               trig_s1, trig_s2, trig_ant;
    logic [2:0]         sync_ok;
    logic               sobe, desce;
    logic [W_LARG-1:0]  cont_larg;
    logic [W_ESP-1:0]   cont_esp;
    logic [W_ECO-1:0]   cont_eco;
    logic [11:0]        dist_lat;
    logic [10:0]        n_cm;
    logic               dist_ok;
    logic [W_ECO-1:0]   largura_eco;

    // sync_ok marks when each synchronizer stage holds a real sample, so a trigger
    // already high at reset release never looks like a rising edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_s1  <= 1'b0;
            trig_s2  <= 1'b0;
            trig_ant <= 1'b0;
            sync_ok  <= '0;
            sobe     <= 1'b0;
            desce    <= 1'b0;
        end else begin
            trig_s1  <= trigger;
            trig_s2  <= trig_s1;
            trig_ant <= trig_s2;
            sync_ok  <= {sync_ok[1:0], 1'b1};
            sobe     <= sync_ok[2] &  trig_s2 & ~trig_ant;
            desce    <= sync_ok[2] & ~trig_s2 &  trig_ant;
        end
    end

    assign n_cm = 11'(dist_lat[11:8]) * 11'd100 + 11'(dist_lat[7:4]) * 11'd10
                + 11'(dist_lat[3:0]);
    assign dist_ok = (dist_lat[11:8] <= 4'd9) && (dist_lat[7:4] <= 4'd9)
                  && (dist_lat[3:0] <= 4'd9) && (n_cm >= 11'd1) && (n_cm <= 11'd400);
    assign largura_eco = dist_ok ? W_ECO'(n_cm) * W_ECO'(R) : W_ECO'(ECO_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= estado_prox;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        estado_prox = estado;
        erro_prox   = 1'b0;
        case (estado)
            INICIAL:      if (sobe) estado_prox = MEDE_TRIGGER;
            MEDE_TRIGGER: if (desce) begin
                if (cont_larg >= W_LARG'(LARGURA_MIN)) begin
                    estado_prox = ESPERA;
                end else begin
                    estado_prox = INICIAL;
                    erro_prox   = 1'b1;
                end
            end
            ESPERA:       if (cont_esp >= W_ESP'(ATRASO)) estado_prox = ECO;
            ECO:          if (cont_eco >= largura_eco) estado_prox = FIM;
            FIM:          estado_prox = INICIAL;
            default:      estado_prox = INICIAL;
        endcase
    end

    // Counters start at 1 on entry so each compares directly against its target width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_larg <= '0;
            cont_esp  <= '0;
            cont_eco  <= '0;
            dist_lat  <= '0;
        end else begin
            case (estado)
                INICIAL: cont_larg <= W_LARG'(1);
                MEDE_TRIGGER: begin
                    if (!desce && cont_larg < W_LARG'(LARGURA_MIN))
                        cont_larg <= cont_larg + W_LARG'(1);
                    if (estado_prox == ESPERA) begin
                        dist_lat <= distancia;
                        cont_esp <= W_ESP'(1);
                    end
                end
                ESPERA: begin
                    if (estado_prox == ECO) cont_eco <= W_ECO'(1);
                    else                    cont_esp <= cont_esp + W_ESP'(1);
                end
                ECO:     if (estado_prox == ECO) cont_eco <= cont_eco + W_ECO'(1);
                default: ;
            endcase
        end
    end

    // Outputs are registered copies of the next state: no input reaches them combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo   <= 1'b0;
            pronto <= 1'b0;
            erro   <= 1'b0;
        end else begin
            echo   <= (estado_prox == ECO);
            pronto <= (estado_prox == FIM);
            erro   <= erro_prox;
        end
    end

    assign db_estado = estado;

endmodule

// File: doc/emulador_hcsr04.md
EMULADOR_HCSR04 -- requirements
Module: emulador_hcsr04

Interface
REQ-001 SHALL have parameter LARGURA_MIN, default 500, minimum valid trigger high width in clocks (10 us at 50 MHz).
REQ-002 SHALL have parameter ATRASO, default 25000, clocks from trigger acceptance to echo rise (500 us burst time).
REQ-003 SHALL have parameter R, default 2941, echo clocks per centimetre.
REQ-004 SHALL have parameter ECO_MAX, default 1900000, echo width in clocks for out-of-range or invalid distance (38 ms).
REQ-005 SHALL have port clock  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port trigger  input  1  asynchronous trigger from the sensor interface.
REQ-008 SHALL have port distancia  input  12  emulated distance, 3 BCD digits [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 SHALL have port echo  output  1  echo pulse; width encodes the distance.
REQ-010 SHALL have port pronto  output  1  one-clock pulse when echo ends.
REQ-011 SHALL have port erro  output  1  one-clock pulse when a trigger is rejected as too short.
REQ-012 SHALL have port db_estado  output  3  current FSM state code.

Function
REQ-013 SHALL pass trigger through a 2-flop synchronizer; all edge detection uses the synchronized signal.
REQ-014 SHALL implement FSM states INICIAL=0, MEDE_TRIGGER=1, ESPERA=2, ECO=3, FIM=4; codes 5-7 go to INICIAL on the next clock.
REQ-015 INICIAL: synchronized rising edge -> MEDE_TRIGGER, with the width counter cleared to 1.
REQ-016 MEDE_TRIGGER: count high cycles, saturating at LARGURA_MIN; on synchronized falling edge, count >= LARGURA_MIN -> ESPERA, otherwise -> INICIAL with erro high for exactly that one transition clock.
REQ-017 SHALL latch distancia on the clock of the MEDE_TRIGGER->ESPERA transition; later changes to distancia SHALL NOT affect the current echo.
REQ-018 SHALL compute echo width from the latched value: N = 100*d2 + 10*d1 + d0; width = N*R clocks if every digit <= 9 and 1 <= N <= 400, otherwise ECO_MAX clocks.
REQ-019 ESPERA: remain exactly ATRASO clocks, then -> ECO; echo SHALL first read high on the clock after the last ESPERA cycle.
REQ-020 SHALL make total latency exactly ATRASO+3 clocks, from the first rising edge sampling trigger low to echo high.
REQ-021 ECO: echo high for exactly the width of REQ-018, as a cm counter nested with a 0..R-1 sub-counter or a single ECO_MAX counter; -> FIM on the last cycle.
REQ-022 FIM: echo low, pronto high for exactly one clock, -> INICIAL.
REQ-023 SHALL ignore trigger activity in ESPERA, ECO and FIM; a trigger still high on return to INICIAL SHALL NOT start a measurement until a fresh rising edge occurs.
REQ-024 SHALL drive echo and pronto from registers with no combinational path from any input.
REQ-025 SHALL keep the trigger width counter at least 10 bits wide and the echo counter at least 21 bits wide, with no wrap within the parameter ranges.

Reset
REQ-026 reset high SHALL asynchronously force state INICIAL, echo=0, pronto=0, erro=0, all counters 0, the latched distance 0 and the synchronizer flops 0.
REQ-027 reset mid-ESPERA or mid-ECO SHALL drop echo in the same cycle and SHALL NOT produce pronto.
REQ-028 After reset release, the first rising edge SHALL be a synchronized trigger rising edge seen from INICIAL; a trigger already high at release SHALL be ignored.

Verification
REQ-029 distancia=12'h025, trigger 600 clocks -> erro never asserts; echo high exactly 73525 clocks, rising ATRASO+3 clocks after trigger falls; pronto for 1 clock at echo end.
REQ-030 distancia=12'h000, then 12'h401, then 12'h0A5 -> each echo is exactly 1900000 clocks wide.
REQ-031 trigger 400 clocks -> erro for 1 clock, state back to 0, echo stays low; a following 500-clock trigger -> normal echo.
REQ-032 distancia=12'h100 latched, changed to 12'h005 during ESPERA -> echo width 294100 clocks.
REQ-033 second trigger pulse during ECO -> ignored; width unchanged; exactly one pronto.
REQ-034 reset asserted mid-ECO -> echo=0 immediately, no pronto, db_estado=0; next valid trigger -> correct echo.
